mips_multicycle_ctrl: RTL
=========================

Name: mips_multicycle_ctrl

Overview:
- Multi-cycle sequencing controller for the MIPS datapath (lw, sw, R-type, addi, beq, bne, j).
- Walks each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK states.
- Drives the shared ALU, memory port, IR, PC and register-file enables.
- Inserts memory wait states on a ready handshake and counts retired instructions.

Parameters:
- COUNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  6  IR[31:26]; stable from DECODE until the next FETCH because IR loads only in FETCH.
- mem_ready  in  1  memory completes the current access this cycle.
- pcwrite  out  1  unconditional PC load.
- pcwritecond_eq  out  1  load PC if ALU zero.
- pcwritecond_ne  out  1  load PC if ALU not zero.
- iord  out  1  memory address source: 0=PC, 1=ALUOut.
- memread  out  1  memory read request.
- memwrite  out  1  memory write request.
- irwrite  out  1  IR load.
- memtoreg  out  1  register write data: 1=MDR, 0=ALUOut.
- regdst  out  1  destination register: 1=rd, 0=rt.
- regwrite  out  1  register-file write enable.
- alusrca  out  1  ALU A input: 0=PC, 1=regA.
- alusrcb  out  2  ALU B input: 00=regB, 01=const 4, 10=signext imm, 11=signext imm<<2.
- aluop  out  2  ALU operation: 00=add, 01=sub, 10=decode funct.
- pcsrc  out  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target.
- illegal_op  out  1  one-cycle pulse on an undefined opcode.
- state  out  4  current state, for debug.
- instr_count  out  COUNT_W  retired instructions.

Behaviour:
- Outputs are decoded combinationally from the state register; only pcwrite and irwrite in FETCH also depend on mem_ready.
- Any signal not listed for a state is 0.
- Reset (async, any time, including mid-instruction or mid-wait):
  - state=IDLE, all outputs 0, instr_count=0.
  - No partial write completes after reset asserts.
- IDLE: all outputs 0 -> FETCH.
- FETCH: memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, irwrite=pcwrite=mem_ready.
  - mem_ready=1 -> DECODE; otherwise stay with outputs held.
- DECODE: alusrca=0, alusrcb=11, aluop=00 (branch target into ALUOut). Next state by opcode:
  - 100011/101011 -> MEMADR
  - 000000 -> EXEC
  - 001000 -> ADDIEX
  - 000100/000101 -> BRANCH
  - 000010 -> JUMP
  - any other opcode -> FETCH with illegal_op=1 this cycle; not counted as retired.
- MEMADR: alusrca=1, alusrcb=10, aluop=00 -> MEMRD if opcode=lw, else MEMWR.
- MEMRD: memread=1, iord=1; wait for mem_ready -> MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdst=0 -> FETCH.
- MEMWR: memwrite=1, iord=1; wait for mem_ready -> FETCH.
- EXEC: alusrca=1, alusrcb=00, aluop=10 -> ALUWB.
- ALUWB: regwrite=1, regdst=1 -> FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00 -> ADDIWB.
- ADDIWB: regwrite=1, regdst=0 -> FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01; pcwritecond_eq=1 for beq, pcwritecond_ne=1 for bne -> FETCH.
- JUMP: pcwrite=1, pcsrc=10 -> FETCH.
- Latency with mem_ready tied 1: lw 5 cycles, sw/R/addi 4, beq/bne/j 3. Each wait cycle adds 1.
- instr_count increments by 1 on each transition into FETCH from MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH or JUMP. It wraps modulo 2^COUNT_W with no saturation.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.
- memread and memwrite are never both 1.
- regwrite is never 1 in the same cycle as memwrite.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_BNE, OP_J)
  - 4-bit state encodings
  - ALUOP_*, SRCB_*, PCSRC_* encodings
- Single module with a state register, next-state logic, output decode and counter; no sub-module is warranted.

Test Plan:
- Reset, release, mem_ready=1, opcode=100011 -> states IDLE,FETCH,DECODE,MEMADR,MEMRD,MEMWB,FETCH; regwrite=1 only in MEMWB; instr_count=1.
- sw with mem_ready=0 for 3 cycles in MEMWR -> memwrite=1, iord=1 held 4 cycles; exactly one FETCH follows; instr_count increments once.
- beq then bne, back-to-back -> BRANCH asserts pcwritecond_eq only, then pcwritecond_ne only; aluop=01, pcsrc=01; 3 cycles each.
- opcode=111111 -> illegal_op high for one cycle in DECODE, return to FETCH, instr_count unchanged.
- rst_n low mid-MEMRD wait -> immediate IDLE, all outputs 0, count 0; after release, first FETCH occurs 1 cycle later.
- COUNT_W=4, 17 j instructions -> instr_count wraps to 1; pcwrite=1, pcsrc=10 in every JUMP.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS sequencing controller:
// opcodes, state codes and the ALU / operand / PC-source selects.
package mips_ctrl_pkg;

  // Opcode field values (IR[31:26]) handled by the controller.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Controller states; the encoding is visible on the debug state port.
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12
  } state_t;

  // ALU operation select.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B operand select.
  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PC source select.
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Successor of DECODE for a given opcode; unknown opcodes fall back to FETCH.
  function automatic state_t decode_next(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW:   return S_MEMADR;
      OP_RTYPE:       return S_EXEC;
      OP_ADDI:        return S_ADDIEX;
      OP_BEQ, OP_BNE: return S_BRANCH;
      OP_J:           return S_JUMP;
      default:        return S_FETCH;
    endcase
  endfunction

  // True when the opcode is one the controller implements.
  function automatic logic opcode_legal(input logic [5:0] op);
    return (decode_next(op) != S_FETCH);
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle sequencing controller for a shared-ALU MIPS datapath.
// Walks lw/sw/R-type/addi/beq/bne/j through fetch, decode, execute,
// memory and writeback states and counts retired instructions.
//
// Memory handshake: in FETCH, MEMRD and MEMWR the controller holds its
// request (memread or memwrite, plus iord) steady every cycle until the
// memory answers with mem_ready=1; the access completes in the cycle where
// request and mem_ready are both high and the FSM leaves the state on that
// edge. mem_ready is ignored in every other state.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pcwrite,
  output logic               pcwritecond_eq,
  output logic               pcwritecond_ne,
  output logic               iord,
  output logic               memread,
  output logic               memwrite,
  output logic               irwrite,
  output logic               memtoreg,
  output logic               regdst,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         aluop,
  output logic [1:0]         pcsrc,
  output logic               illegal_op,
  output logic [3:0]         state,
  output logic [COUNT_W-1:0] instr_count
);

  state_t               state_q;
  state_t               state_d;
  logic                 retire;
  logic [COUNT_W-1:0]   instr_count_q;

  // Next-state selection; wait states simply hold the current state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: state_d = decode_next(opcode);
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  // An instruction retires on the edge that takes its final state back to
  // FETCH; an illegal opcode returns from DECODE and is not counted.
  always_comb begin
    retire = 1'b0;
    unique case (state_q)
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: retire = 1'b1;
      S_MEMWR: retire = mem_ready;
      default: retire = 1'b0;
    endcase
  end

  // State register and retired-instruction counter (wraps, no saturation).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      instr_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) begin
        instr_count_q <= instr_count_q + COUNT_W'(1);
      end
    end
  end

  // Control decode from the current state; anything not driven is 0.
  always_comb begin
    pcwrite        = 1'b0;
    pcwritecond_eq = 1'b0;
    pcwritecond_ne = 1'b0;
    iord           = 1'b0;
    memread        = 1'b0;
    memwrite       = 1'b0;
    irwrite        = 1'b0;
    memtoreg       = 1'b0;
    regdst         = 1'b0;
    regwrite       = 1'b0;
    alusrca        = 1'b0;
    alusrcb        = SRCB_REGB;
    aluop          = ALUOP_ADD;
    pcsrc          = PCSRC_ALU;
    illegal_op     = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        // PC+4 and IR load only land in the cycle the read completes.
        memread = 1'b1;
        alusrcb = SRCB_FOUR;
        irwrite = mem_ready;
        pcwrite = mem_ready;
      end
      S_DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        alusrcb    = SRCB_IMM_SH2;
        illegal_op = ~opcode_legal(opcode);
      end
      S_MEMADR, S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      S_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      S_EXEC: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
      end
      S_BRANCH: begin
        alusrca        = 1'b1;
        aluop          = ALUOP_SUB;
        pcsrc          = PCSRC_ALUOUT;
        pcwritecond_eq = (opcode == OP_BEQ);
        pcwritecond_ne = (opcode == OP_BNE);
      end
      S_JUMP: begin
        pcwrite = 1'b1;
        pcsrc   = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

  assign state       = state_q;
  assign instr_count = instr_count_q;

endmodule
